// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester round-robin front end for a shared combinational ALU
module alu_arbiter #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             req1,
    input  logic [1:0]       sel0,
    input  logic [1:0]       sel1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             ack0,
    output logic             ack1,
    output logic [WIDTH:0]   res,
    output logic             busy,
    output logic [1:0]       alu_select,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH:0]   alu_res,
    output logic [7:0]       op_count
);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
    state_t state, state_nx;
    logic win, ptr, grant, pick;
    logic [WIDTH:0] cap;
    // the ack cycle still belongs to the operation, so no grant is made during it
    always_comb begin
        grant = (state == IDLE) && !ack0 && !ack1 && (req0 || req1);
        pick = (req0 && req1) ? ptr : req1;
        state_nx = (state == EXEC) ? DONE : (state == DONE) ? IDLE : (grant ? EXEC : IDLE);
    end
    assign busy = (state != IDLE) || ack0 || ack1;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            win <= 1'b0;
            ptr <= 1'b0;
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            res <= '0;
            cap <= '0;
            alu_select <= '0;
            alu_a <= '0;
            alu_b <= '0;
            op_count <= '0;
        end else begin
            state <= state_nx;
            ack0 <= (state == DONE) && !win;
            ack1 <= (state == DONE) && win;
            if (grant) begin
                win <= pick;
                alu_select <= pick ? sel1 : sel0;
                alu_a <= pick ? a1 : a0;
                alu_b <= pick ? b1 : b0;
            end
            if (state == EXEC) cap <= alu_res;
            if (state == DONE) begin
                res <= cap;
                op_count <= op_count + 8'd1;
                ptr <= ~win;
            end
        end
    end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: WIDTH, default 5, operand width; result width is WIDTH+1.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 req0, req1  input  1 each  operation request from requester 0 / 1.
REQ-005 sel0, sel1  input  2 each  ALU operation select from requester 0 / 1.
REQ-006 a0, b0, a1, b1  input  WIDTH each  operands from requester 0 / 1.
REQ-007 ack0, ack1  output  1 each  one-cycle completion pulse to requester 0 / 1.
REQ-008 res  output  WIDTH+1  captured ALU result; valid while ack0 or ack1 is high.
REQ-009 busy  output  1  high whenever the state is not IDLE.
REQ-010 alu_select  output  2, alu_a  output  WIDTH, alu_b  output  WIDTH  registered drive to the shared combinational ALU.
REQ-011 alu_res  input  WIDTH+1  combinational result from the shared ALU.
REQ-012 op_count  output  8  number of completed operations.

Function
REQ-013 The FSM SHALL have three states: IDLE, EXEC, DONE.
REQ-014 IDLE: no request -> stay; any request -> latch winner's sel/a/b into alu_select/alu_a/alu_b, record winner, go EXEC.
REQ-015 EXEC: capture alu_res into the result register, go DONE (one full cycle for ALU settling).
REQ-016 DONE: assert ack of the recorded winner for exactly one cycle with res = captured value, increment op_count, update the priority pointer, go IDLE.
REQ-017 Latency: req high at edge N -> ack high in the cycle following edge N+2; the next grant is at edge N+4 at the earliest.
REQ-018 Single request: the requesting side wins regardless of the priority pointer.
REQ-019 Simultaneous requests: the side not served last wins; after reset, requester 0 wins the first tie.
REQ-020 Pointer SHALL change only in DONE, set to favour the side not just served.
REQ-021 Requests SHALL be ignored outside IDLE; operands are sampled only at the grant edge, and later operand changes do not affect the operation in flight.
REQ-022 A winner dropping req before ack SHALL NOT abort the operation; ack is still issued.
REQ-023 Requester protocol: hold req and operands until ack; drop req on the edge ending the ack cycle. The DONE->IDLE edge does not sample requests, so a dropped req is never re-granted.
REQ-024 ack0 and ack1 SHALL never be high together; res holds its last value between acks.
REQ-025 op_count SHALL wrap 255 -> 0.
REQ-026 alu_select/alu_a/alu_b SHALL hold their last granted values until the next grant.

Reset
REQ-027 rst_n low SHALL immediately force: state IDLE, ack0=ack1=0, busy=0, res=0, alu_select=0, alu_a=0, alu_b=0, op_count=0, pointer favouring requester 0.
REQ-028 Reset asserted mid-operation (EXEC or DONE) SHALL abandon the operation with no ack and no op_count increment.
REQ-029 The first grant SHALL occur at the first rising edge with rst_n high and a request present.

Verification
For all scenarios, the bench ALU model returns alu_res = alu_a + alu_b for select 0 and alu_a - alu_b for select 1.
REQ-030 req0=1, sel0=0, a0=10, b0=7 -> alu_a=10, alu_b=7 after the grant edge; ack0 high 3rd cycle; res=17; op_count=1; busy high for 3 cycles.
REQ-031 req0 and req1 both high from reset, (a0,b0,sel0)=(10,7,0), (a1,b1,sel1)=(10,7,1) -> ack0 with res=17 first, then ack1 with res=3; never both acks high.
REQ-032 Both requesters held continuously for 6 operations -> grants alternate 0,1,0,1,0,1; op_count=6.
REQ-033 req1 granted with a1=5, then a1 changed to 9 during EXEC -> res reflects 5; ack1 still issued.
REQ-034 rst_n pulsed low during EXEC -> all outputs zero immediately; no ack; op_count=0; next request is served normally from IDLE.
REQ-035 257 single operations -> op_count=1 after wrap.
